serial_addsub_signmag: RTL and testbench

- Parametrised, multi-cycle unsigned adder/subtractor. Processes operands DIGIT bits per clock through one shared DIGIT-bit adder slice that uses a + ~b + 1 for subtract.
- In subtract mode it returns a sign-magnitude result. A negative difference is corrected to its magnitude by a final two's-complement pass.
- Sits in the arithmetic_circuits family as the sequential, width-generic successor to the fixed 4-bit ripple subtractor. It trades area for latency.

---
 rtl/serial_addsub_signmag_if.sv | 25 ++
 rtl/serial_addsub_signmag.sv | 131 +++++++++++++
 tb/tb_serial_addsub_signmag.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_signmag_if.sv
// Operand/result bundle for the digit-serial sign-magnitude adder/subtractor.
// The master side issues operations and the slave side is the arithmetic unit.
interface serial_addsub_signmag_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             neg;
  logic             cout;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, neg, cout
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, neg, cout
  );
endinterface

// File: rtl/serial_addsub_signmag.sv
// Digit-serial unsigned add/subtract through one shared DIGIT-bit slice. A subtract
// uses a + ~b + 1, and a final pass folds a negative difference into sign-magnitude form.
module serial_addsub_signmag #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                   clk,
  input logic                   rst,
  serial_addsub_signmag_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_addsub_signmag: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CORR = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, acc_reg, result_reg;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             mode_reg, carry_reg, neg_reg, cout_reg, done_reg;
  logic             load, step, finish, last_digit, borrow;
  logic [DIGIT-1:0] sum_digit;
  logic [DIGIT:0]   chain;

  assign last_digit = (cnt_reg == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last_digit) state_next = ST_CORR;
      ST_CORR: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state_reg)
      ST_IDLE: load   = bus.start;
      ST_RUN:  step   = 1'b1;
      ST_CORR: finish = 1'b1;
      default: ;
    endcase
  end

  // Shared ripple slice: the carry register feeds bit 0 and receives the top carry.
  assign chain[0] = carry_reg;
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
      assign sum_digit[gi] = a_sh_reg[gi] ^ b_sh_reg[gi] ^ chain[gi];
      assign chain[gi+1]   = (a_sh_reg[gi] & b_sh_reg[gi]) |
                             (chain[gi] & (a_sh_reg[gi] ^ b_sh_reg[gi]));
    end
  endgenerate

  // Sum digits enter from the MSB side so the first digit ends at bit 0.
  generate
    if (N == 1) begin : g_acc_single
      assign acc_next = sum_digit;
    end else begin : g_acc_shift
      assign acc_next = {sum_digit, acc_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign borrow = mode_reg & ~carry_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      neg_reg    <= 1'b0;
      cout_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      if (load) begin
        a_sh_reg  <= bus.a;
        b_sh_reg  <= bus.mode ? ~bus.b : bus.b;
        mode_reg  <= bus.mode;
        carry_reg <= bus.mode;
        acc_reg   <= '0;
        cnt_reg   <= '0;
      end
      if (step) begin
        a_sh_reg  <= a_sh_reg >> DIGIT;
        b_sh_reg  <= b_sh_reg >> DIGIT;
        acc_reg   <= acc_next;
        carry_reg <= chain[DIGIT];
        cnt_reg   <= cnt_reg + 1'b1;
      end
      if (finish) begin
        result_reg <= borrow ? (~acc_reg + WIDTH'(1)) : acc_reg;
        neg_reg    <= borrow;
        cout_reg   <= mode_reg ? borrow : carry_reg;
      end
      done_reg <= finish;
    end
  end

  assign bus.busy   = (state_reg != ST_IDLE);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.neg    = neg_reg;
  assign bus.cout   = cout_reg;
endmodule

// File: tb/tb_serial_addsub_signmag.sv
// Randomised and directed checks of serial_addsub_signmag in three configurations
// (8/1, 8/4, 16/2) against an arithmetic reference model.
module tb_serial_addsub_signmag;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_addsub_signmag_if #(.WIDTH(8))  if81 ();
  serial_addsub_signmag_if #(.WIDTH(8))  if84 ();
  serial_addsub_signmag_if #(.WIDTH(16)) if162 ();

  serial_addsub_signmag #(.WIDTH(8),  .DIGIT(1)) dut81  (.clk(clk), .rst(rst), .bus(if81.slave));
  serial_addsub_signmag #(.WIDTH(8),  .DIGIT(4)) dut84  (.clk(clk), .rst(rst), .bus(if84.slave));
  serial_addsub_signmag #(.WIDTH(16), .DIGIT(2)) dut162 (.clk(clk), .rst(rst), .bus(if162.slave));

  task automatic drive(input int w, input logic s, input logic m,
                       input logic [15:0] a, input logic [15:0] b);
    case (w)
      0:       begin if81.start = s;  if81.mode = m;  if81.a = a[7:0];  if81.b = b[7:0];  end
      1:       begin if84.start = s;  if84.mode = m;  if84.a = a[7:0];  if84.b = b[7:0];  end
      default: begin if162.start = s; if162.mode = m; if162.a = a;      if162.b = b;      end
    endcase
  endtask

  task automatic sample(input int w, output logic bsy, output logic dn,
                        output logic ng, output logic co, output logic [15:0] res);
    case (w)
      0:       begin bsy = if81.busy;  dn = if81.done;  ng = if81.neg;  co = if81.cout;  res = {8'd0, if81.result}; end
      1:       begin bsy = if84.busy;  dn = if84.done;  ng = if84.neg;  co = if84.cout;  res = {8'd0, if84.result}; end
      default: begin bsy = if162.busy; dn = if162.done; ng = if162.neg; co = if162.cout; res = if162.result;         end
    endcase
  endtask

  // Reference: plain unsigned arithmetic on the operand width.
  function automatic void ref_op(input int width, input logic m, input logic [15:0] a,
                                 input logic [15:0] b, output logic [15:0] res,
                                 output logic ng, output logic co);
    longint unsigned mask, aa, bb, s;
    mask = (64'd1 << width) - 64'd1;
    aa   = longint'(a) & mask;
    bb   = longint'(b) & mask;
    if (!m) begin
      s   = aa + bb;
      res = 16'(s & mask);
      co  = ((s >> width) != 0);
      ng  = 1'b0;
    end else begin
      ng  = (aa < bb);
      co  = ng;
      res = 16'(ng ? (bb - aa) : (aa - bb));
    end
  endfunction

  // Launch one op, scramble the inputs after acceptance, and wait for done.
  // lat counts edges after the accepting edge; busy_cyc counts busy cycles.
  task automatic run_op(input int w, input logic m, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int busy_cyc, output logic [15:0] res,
                        output logic ng, output logic co);
    logic bsy, dn;
    @(negedge clk);
    drive(w, 1'b1, m, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, ~m, 16'($urandom), 16'($urandom));
    lat = 0;
    busy_cyc = 0;
    sample(w, bsy, dn, ng, co, res);
    while (!dn && lat < 40) begin
      if (bsy) busy_cyc++;
      @(negedge clk);
      lat++;
      sample(w, bsy, dn, ng, co, res);
    end
    $display("op cfg=%0d mode=%0d a=%0h b=%0h -> result=%0h neg=%0d cout=%0d lat=%0d",
             w, m, a, b, res, ng, co, lat);
  endtask

  task automatic test_reset;
    logic bsy, dn, ng, co;
    logic [15:0] res;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      sample(w, bsy, dn, ng, co, res);
      checks++;
      if ({bsy, dn, ng, co, res} !== 20'd0) begin
        errors++;
        $display("FAIL reset cfg%0d: got busy=%b done=%b neg=%b cout=%b result=%0h, want all 0",
                 w, bsy, dn, ng, co, res);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sub_basic;
    int lat, bc;
    logic bsy, dn, ng, co;
    logic [15:0] res;
    run_op(0, 1'b1, 16'd6, 16'd9, lat, bc, res, ng, co);
    checks++; if (lat !== 9)  begin errors++; $display("FAIL sub6-9 latency: got %0d want 9", lat); end
    checks++; if (bc !== 9)   begin errors++; $display("FAIL sub6-9 busy cycles: got %0d want 9", bc); end
    checks++; if (res !== 16'd3) begin errors++; $display("FAIL sub6-9 result: got %0d want 3", res); end
    checks++; if ({ng, co} !== 2'b11) begin errors++; $display("FAIL sub6-9 neg/cout: got %b%b want 11", ng, co); end
    @(negedge clk);
    sample(0, bsy, dn, ng, co, res);
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL done pulse width: got done=%b want 0", dn); end
    checks++; if (res !== 16'd3) begin errors++; $display("FAIL result hold: got %0d want 3", res); end
  endtask

  task automatic test_add_and_equal;
    int lat, bc;
    logic ng, co;
    logic [15:0] res;
    run_op(0, 1'b0, 16'd200, 16'd100, lat, bc, res, ng, co);
    checks++; if (res !== 16'd44) begin errors++; $display("FAIL add200+100 result: got %0d want 44", res); end
    checks++; if ({ng, co} !== 2'b01) begin errors++; $display("FAIL add200+100 neg/cout: got %b%b want 01", ng, co); end
    run_op(0, 1'b1, 16'd9, 16'd9, lat, bc, res, ng, co);
    checks++; if ({res, ng, co} !== 18'd0) begin errors++; $display("FAIL sub9-9: got result=%0d neg=%b cout=%b want 0 0 0", res, ng, co); end
  endtask

  task automatic test_digit4;
    int lat, bc;
    logic ng, co;
    logic [15:0] res;
    run_op(1, 1'b1, 16'd0, 16'd255, lat, bc, res, ng, co);
    checks++; if (lat !== 3) begin errors++; $display("FAIL d4 sub0-255 latency: got %0d want 3", lat); end
    checks++; if (res !== 16'd255) begin errors++; $display("FAIL d4 sub0-255 result: got %0d want 255", res); end
    checks++; if ({ng, co} !== 2'b11) begin errors++; $display("FAIL d4 sub0-255 neg/cout: got %b%b want 11", ng, co); end
    run_op(1, 1'b1, 16'd200, 16'd55, lat, bc, res, ng, co);
    checks++; if (res !== 16'd145) begin errors++; $display("FAIL d4 sub200-55 result: got %0d want 145", res); end
    checks++; if ({ng, co} !== 2'b00) begin errors++; $display("FAIL d4 sub200-55 neg/cout: got %b%b want 00", ng, co); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int extra_busy;
    logic bsy, dn, ng, co;
    logic [15:0] res;
    // start stays high through RUN and the done cycle; only the done-cycle request is taken.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'd6, 16'd9);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd1, 16'd2);
    lat = 0;
    sample(0, bsy, dn, ng, co, res);
    while (!dn && lat < 40) begin @(negedge clk); lat++; sample(0, bsy, dn, ng, co, res); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b first latency: got %0d want 9", lat); end
    checks++; if ({res, ng, co} !== {16'd3, 2'b11}) begin errors++; $display("FAIL b2b first: got result=%0d neg=%b cout=%b want 3 1 1", res, ng, co); end
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'd77, 16'd99);
    lat = 0;
    sample(0, bsy, dn, ng, co, res);
    while (!dn && lat < 40) begin @(negedge clk); lat++; sample(0, bsy, dn, ng, co, res); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b second latency: got %0d want 9", lat); end
    checks++; if ({res, ng, co} !== {16'd3, 2'b00}) begin errors++; $display("FAIL b2b second: got result=%0d neg=%b cout=%b want 3 0 0", res, ng, co); end
    $display("op back-to-back second add 1+2 -> result=%0h neg=%0d cout=%0d", res, ng, co);

    // Start pulse in the middle of RUN must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd100, 16'd27);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    lat = 0;
    sample(0, bsy, dn, ng, co, res);
    while (!dn && lat < 40) begin
      if (lat == 3) drive(0, 1'b1, 1'b1, 16'd0, 16'd255);
      else          drive(0, 1'b0, 1'b1, 16'd0, 16'd255);
      @(negedge clk);
      lat++;
      sample(0, bsy, dn, ng, co, res);
    end
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    checks++; if ({res, ng, co} !== {16'd127, 2'b00}) begin errors++; $display("FAIL midrun start: got result=%0d neg=%b cout=%b want 127 0 0", res, ng, co); end
    extra_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(0, bsy, dn, ng, co, res);
      if (bsy) extra_busy++;
    end
    checks++; if (extra_busy !== 0) begin errors++; $display("FAIL midrun start relaunch: got %0d busy cycles want 0", extra_busy); end
    $display("op ignored mid-run start -> result=%0h busy_after=%0d", res, extra_busy);
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, dones;
    logic bsy, dn, ng, co;
    logic [15:0] res;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'd50, 16'd60);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 sample(0, bsy, dn, ng, co, res);
    checks++;
    if ({bsy, dn, ng, co, res} !== 20'd0) begin
      errors++;
      $display("FAIL async reset mid-run: got busy=%b done=%b neg=%b cout=%b result=%0h want all 0",
               bsy, dn, ng, co, res);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(0, bsy, dn, ng, co, res);
      if (dn || bsy) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL aborted op activity: got %0d busy/done cycles want 0", dones); end
    run_op(0, 1'b1, 16'd15, 16'd4, lat, bc, res, ng, co);
    checks++; if ({res, ng, co} !== {16'd11, 2'b00}) begin errors++; $display("FAIL sub15-4 after reset: got result=%0d neg=%b cout=%b want 11 0 0", res, ng, co); end
  endtask

  task automatic test_random;
    int lat, bc;
    logic m, ng, co, ng_exp, co_exp;
    logic [15:0] a, b, res, res_exp;
    for (int i = 0; i < 500; i++) begin
      m = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 50 == 0) b = a;
      if (i % 50 == 1) begin a = 16'd0; b = 16'hffff; end
      run_op(2, m, a, b, lat, bc, res, ng, co);
      ref_op(16, m, a, b, res_exp, ng_exp, co_exp);
      checks++; if (lat !== 9) begin errors++; $display("FAIL rand#%0d latency: got %0d want 9", i, lat); end
      checks++; if (res !== res_exp) begin errors++; $display("FAIL rand#%0d result: got %0h want %0h", i, res, res_exp); end
      checks++; if (ng !== ng_exp) begin errors++; $display("FAIL rand#%0d neg: got %b want %b", i, ng, ng_exp); end
      checks++; if (co !== co_exp) begin errors++; $display("FAIL rand#%0d cout: got %b want %b", i, co, co_exp); end
    end
  endtask

  initial begin
    test_reset();
    test_sub_basic();
    test_add_and_equal();
    test_digit4();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
